// File: rtl/duty_ramp.sv
// Slews the PWM duty word toward a commanded target one STEP per PWM period,
// braking through a zero-duty dead time on direction reversal, with emergency stop.
module duty_ramp #(
    parameter int WIDTH        = 8,
    parameter int STEP         = 4,
    parameter int DEAD_PERIODS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_duty,
    input  logic             new_dc,
    input  logic             estop,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             dir,
    output logic             at_target,
    output logic             busy
);

    localparam int CW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [CW-1:0]  DEAD_LAST = CW'(DEAD_PERIODS - 1);
    localparam logic [WIDTH:0] STEP_W    = (WIDTH + 1)'(STEP);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RAMP,
        S_BRAKE,
        S_DEAD,
        S_ESTOP
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  duty_q, duty_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  tgt_duty_q, tgt_duty_d;
    logic              tgt_dir_q, tgt_dir_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]    duty_ext, tgt_ext, sum_up, diff_down;
    logic [WIDTH-1:0]  toward_val, brake_val;

    // One extra bit of headroom keeps both saturating steps free of wrap-around.
    always_comb begin
        duty_ext  = {1'b0, duty_q};
        tgt_ext   = {1'b0, tgt_duty_q};
        sum_up    = duty_ext + STEP_W;
        diff_down = duty_ext - STEP_W;
        if (duty_q < tgt_duty_q) begin
            toward_val = (sum_up >= tgt_ext) ? tgt_duty_q : sum_up[WIDTH-1:0];
        end else begin
            toward_val = (duty_ext >= tgt_ext + STEP_W) ? diff_down[WIDTH-1:0] : tgt_duty_q;
        end
        brake_val = (duty_ext > STEP_W) ? diff_down[WIDTH-1:0] : '0;
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        tgt_duty_d = tgt_duty_q;
        tgt_dir_d  = tgt_dir_q;
        cnt_d      = cnt_q;
        if (estop) begin
            duty_d     = '0;
            tgt_duty_d = '0;
            tgt_dir_d  = dir_q;
            state_d    = S_ESTOP;
        end else begin
            // A zero-magnitude command keeps the present direction so it never reverses.
            if (cmd_valid && cmd_ready) begin
                tgt_duty_d = cmd_duty;
                tgt_dir_d  = (cmd_duty == '0) ? dir_q : cmd_dir;
            end
            unique case (state_q)
                S_ESTOP: state_d = S_HOLD;
                S_DEAD: begin
                    if (new_dc) begin
                        duty_d = '0;
                        if (cnt_q == DEAD_LAST) begin
                            dir_d   = tgt_dir_q;
                            state_d = S_RAMP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (new_dc) begin
                        if (tgt_dir_q != dir_q) begin
                            duty_d = brake_val;
                            if (brake_val == '0) begin
                                state_d = S_DEAD;
                                cnt_d   = '0;
                            end else begin
                                state_d = S_BRAKE;
                            end
                        end else begin
                            duty_d  = toward_val;
                            state_d = (toward_val == tgt_duty_q) ? S_HOLD : S_RAMP;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_HOLD;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            tgt_duty_q <= '0;
            tgt_dir_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cmd_ready  = (state_q != S_DEAD) && (state_q != S_ESTOP);
    assign at_target  = (duty_q == tgt_duty_q) && (dir_q == tgt_dir_q) &&
                        (state_q != S_DEAD) && (state_q != S_ESTOP);
    assign busy       = !at_target;
    assign duty_cycle = duty_q;
    assign dir        = dir_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: expected duty/dir per PWM pulse are queued
// as stimulus is issued and compared once the DUT has taken the pulse.
module tb_duty_ramp;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_duty = '0;
    logic       new_dc = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] duty_cycle;
    logic       dir;
    logic       at_target;
    logic       busy;

    typedef struct {
        logic [7:0] duty;
        logic       dir;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    duty_ramp #(.WIDTH(8), .STEP(4), .DEAD_PERIODS(3)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .new_dc(new_dc), .estop(estop),
        .duty_cycle(duty_cycle), .dir(dir), .at_target(at_target), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // new_dc arrives once every 20 cycles, like the real PWM generator.
    task automatic pulse();
        repeat (19) tick();
        new_dc = 1'b1;
        tick();
        new_dc = 1'b0;
    endtask

    task automatic pulse_n(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic push_exp(input logic [7:0] d, input logic r);
        exp_t e;
        e.duty = d;
        e.dir  = r;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic d, input logic [7:0] m);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            total_cnt++;
            $display("[TB] FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_duty  = m;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
        total_cnt++; if (duty_cycle !== 8'd0) $display("[TB] FAIL reset_duty: got %0d required 0", duty_cycle); else pass_cnt++;
        total_cnt++; if (dir !== 1'b0) $display("[TB] FAIL reset_dir: got %b required 0", dir); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b required 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL reset_at_target: got %b required 1", at_target); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    endtask

    task automatic test_ramp();
        exp_t e;
        send_cmd(1'b0, 8'd10);
        push_exp(8'd4, 1'b0);
        push_exp(8'd8, 1'b0);
        push_exp(8'd10, 1'b0);
        while (sb.size() > 0) begin
            pulse();
            e = sb.pop_front();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL ramp_duty: got %0d required %0d", duty_cycle, e.duty); else pass_cnt++;
            repeat (10) tick();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL ramp_stable: got %0d required %0d", duty_cycle, e.duty); else pass_cnt++;
        end
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL ramp_at_target: got %b required 1", at_target); else pass_cnt++;
    endtask

    task automatic test_saturation();
        exp_t e;
        send_cmd(1'b0, 8'd250);
        pulse_n(60);
        total_cnt++; if (duty_cycle !== 8'd250) $display("[TB] FAIL sat_reach250: got %0d required 250", duty_cycle); else pass_cnt++;
        send_cmd(1'b0, 8'd255);
        push_exp(8'd254, 1'b0);
        push_exp(8'd255, 1'b0);
        while (sb.size() > 0) begin
            pulse();
            e = sb.pop_front();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL sat_top: got %0d required %0d", duty_cycle, e.duty); else pass_cnt++;
        end
        send_cmd(1'b0, 8'd3);
        pulse_n(63);
        total_cnt++; if (duty_cycle !== 8'd3) $display("[TB] FAIL sat_reach3: got %0d required 3", duty_cycle); else pass_cnt++;
        send_cmd(1'b1, 8'd0);
        push_exp(8'd0, 1'b0);
        while (sb.size() > 0) begin
            pulse();
            e = sb.pop_front();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL sat_bottom: got %0d required %0d", duty_cycle, e.duty); else pass_cnt++;
            total_cnt++; if (dir !== e.dir) $display("[TB] FAIL sat_zero_dir: got %b required %b", dir, e.dir); else pass_cnt++;
        end
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL sat_zero_at_target: got %b required 1", at_target); else pass_cnt++;
        // Command and pulse on the same edge: this step must still see the old target of 0.
        repeat (19) tick();
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_duty  = 8'd10;
        new_dc    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        new_dc    = 1'b0;
        total_cnt++; if (duty_cycle !== 8'd0) $display("[TB] FAIL same_cycle_duty: got %0d required 0", duty_cycle); else pass_cnt++;
        total_cnt++; if (at_target !== 1'b0) $display("[TB] FAIL same_cycle_at_target: got %b required 0", at_target); else pass_cnt++;
        push_exp(8'd4, 1'b0);
        push_exp(8'd8, 1'b0);
        push_exp(8'd10, 1'b0);
        while (sb.size() > 0) begin
            pulse();
            e = sb.pop_front();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL same_cycle_ramp: got %0d required %0d", duty_cycle, e.duty); else pass_cnt++;
        end
    endtask

    task automatic test_reversal();
        exp_t e;
        int   i = 0;
        send_cmd(1'b1, 8'd8);
        push_exp(8'd6, 1'b0);
        push_exp(8'd2, 1'b0);
        push_exp(8'd0, 1'b0);
        push_exp(8'd0, 1'b0);
        push_exp(8'd0, 1'b0);
        push_exp(8'd0, 1'b1);
        push_exp(8'd4, 1'b1);
        push_exp(8'd8, 1'b1);
        while (sb.size() > 0) begin
            pulse();
            e = sb.pop_front();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL rev_duty_%0d: got %0d required %0d", i, duty_cycle, e.duty); else pass_cnt++;
            total_cnt++; if (dir !== e.dir) $display("[TB] FAIL rev_dir_%0d: got %b required %b", i, dir, e.dir); else pass_cnt++;
            if (i == 2) begin
                total_cnt++; if (cmd_ready !== 1'b0) $display("[TB] FAIL rev_dead_ready: got %b required 0", cmd_ready); else pass_cnt++;
                total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL rev_dead_busy: got %b required 1", busy); else pass_cnt++;
            end
            i++;
        end
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL rev_at_target: got %b required 1", at_target); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rev_ready: got %b required 1", cmd_ready); else pass_cnt++;
    endtask

    task automatic test_cancelled_reversal();
        exp_t e;
        int   i = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send_cmd(1'b0, 8'd10);
        pulse_n(3);
        send_cmd(1'b1, 8'd8);
        push_exp(8'd6, 1'b0);
        push_exp(8'd10, 1'b0);
        push_exp(8'd12, 1'b0);
        while (sb.size() > 0) begin
            pulse();
            e = sb.pop_front();
            total_cnt++; if (duty_cycle !== e.duty) $display("[TB] FAIL cancel_duty_%0d: got %0d required %0d", i, duty_cycle, e.duty); else pass_cnt++;
            total_cnt++; if (dir !== e.dir) $display("[TB] FAIL cancel_dir_%0d: got %b required %b", i, dir, e.dir); else pass_cnt++;
            total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL cancel_ready_%0d: got %b required 1", i, cmd_ready); else pass_cnt++;
            if (i == 0) send_cmd(1'b0, 8'd12);
            i++;
        end
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL cancel_at_target: got %b required 1", at_target); else pass_cnt++;
    endtask

    task automatic test_estop();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send_cmd(1'b0, 8'd20);
        pulse_n(2);
        total_cnt++; if (duty_cycle !== 8'd8) $display("[TB] FAIL estop_pre_duty: got %0d required 8", duty_cycle); else pass_cnt++;
        estop = 1'b1;
        tick();
        total_cnt++; if (duty_cycle !== 8'd0) $display("[TB] FAIL estop_duty: got %0d required 0", duty_cycle); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b0) $display("[TB] FAIL estop_ready: got %b required 0", cmd_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL estop_busy: got %b required 1", busy); else pass_cnt++;
        pulse();
        total_cnt++; if (duty_cycle !== 8'd0) $display("[TB] FAIL estop_pulse_duty: got %0d required 0", duty_cycle); else pass_cnt++;
        estop = 1'b0;
        tick();
        total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL estop_release_ready: got %b required 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL estop_release_at_target: got %b required 1", at_target); else pass_cnt++;
        send_cmd(1'b0, 8'd4);
        pulse();
        total_cnt++; if (duty_cycle !== 8'd4) $display("[TB] FAIL estop_resume_duty: got %0d required 4", duty_cycle); else pass_cnt++;
    endtask

    task automatic test_clr_in_dead();
        send_cmd(1'b1, 8'd4);
        pulse_n(5);
        total_cnt++; if (dir !== 1'b1) $display("[TB] FAIL dead_flip_dir: got %b required 1", dir); else pass_cnt++;
        total_cnt++; if (duty_cycle !== 8'd4) $display("[TB] FAIL dead_flip_duty: got %0d required 4", duty_cycle); else pass_cnt++;
        send_cmd(1'b0, 8'd4);
        pulse();
        total_cnt++; if (cmd_ready !== 1'b0) $display("[TB] FAIL dead_ready: got %b required 0", cmd_ready); else pass_cnt++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total_cnt++; if (duty_cycle !== 8'd0) $display("[TB] FAIL clr_dead_duty: got %0d required 0", duty_cycle); else pass_cnt++;
        total_cnt++; if (dir !== 1'b0) $display("[TB] FAIL clr_dead_dir: got %b required 0", dir); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b1) $display("[TB] FAIL clr_dead_ready: got %b required 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (at_target !== 1'b1) $display("[TB] FAIL clr_dead_at_target: got %b required 1", at_target); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL clr_dead_busy: got %b required 0", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_reversal();
        test_cancelled_reversal();
        test_estop();
        test_clr_in_dead();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
